// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc,inst} queue between instruction memory and decode; flush empties it in one edge.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch: owns the PC, issues word fetches and queues in-order responses for decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module inst_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [CW-1:0] inflight, inflight_nxt;
  logic [CW-1:0] drop, drop_nxt;
  logic [CW-1:0] stale;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push, pop, q_valid, byp, req_fire;
  logic [31:0]   rsp_pc;
  fetch_entry_t  head, push_data;

  // Outstanding requests are consecutive words ending at pc-4, so the oldest is pc - 4*inflight.
  assign rsp_pc        = pc - (32'(inflight) << 2);
  assign stale         = inflight - CW'(imem_rsp_valid);
  assign imem_req_addr = pc;
  assign push_data     = '{pc: rsp_pc, inst: imem_rsp_data};

`ifdef IFQ_BYPASS_EN
  assign byp = (state == FETCH) && fifo_empty && imem_rsp_valid && !redirect_valid;
`else
  assign byp = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    inflight_nxt = inflight;
    drop_nxt     = drop;

    q_valid        = (state == FETCH) && !fifo_empty;
    imem_req_valid = (state == FETCH) && !redirect_valid &&
                     ((SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;

    id_valid = q_valid || byp;
    id_inst  = q_valid ? head.inst : (byp ? imem_rsp_data : INST_NOP);
    id_pc    = q_valid ? head.pc   : (byp ? rsp_pc        : 32'h0);

    pop  = q_valid && id_ready && !redirect_valid;
    push = (state == FETCH) && imem_rsp_valid && !redirect_valid && !(byp && id_ready);

    // Redirect wins in every state; anything still outstanding becomes stale.
    if (redirect_valid) begin
      pc_nxt       = redirect_pc & ~32'h3;
      inflight_nxt = stale;
      drop_nxt     = stale;
      state_nxt    = (stale != '0) ? DRAIN : FETCH;
    end else begin
      unique case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (req_fire) pc_nxt = pc + 32'd4;
          inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            inflight_nxt = inflight - CW'(1);
            drop_nxt     = drop - CW'(1);
          end
          if (drop_nxt == '0) state_nxt = FETCH;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule
